// File: rtl/exu_alu_wb_if.sv
// ----------------------------------------------------------------------------
// exu_alu_wb_if
//   Bundle of the ALU writeback buffer's handshake and bus signals.
//
//   Upstream ALU side : flush, s0_valid, s0_ready, s0_rd_wen, s0_rd_idx,
//                       s0_word, s0_alu_result
//   Regfile write side: wb_valid, wb_ready, wb_rd_idx, wb_data
//   Operand bypass    : byp_rs_idx, byp_hit, byp_data
//
//   modport slave  : the writeback buffer itself
//   modport master : the surrounding pipeline (ALU, regfile, operand stage)
// ----------------------------------------------------------------------------
interface exu_alu_wb_if #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
);
  logic              flush;
  logic              s0_valid;
  logic              s0_ready;
  logic              s0_rd_wen;
  logic [RIDX_W-1:0] s0_rd_idx;
  logic              s0_word;
  logic [XLEN-1:0]   s0_alu_result;
  logic              wb_valid;
  logic              wb_ready;
  logic [RIDX_W-1:0] wb_rd_idx;
  logic [XLEN-1:0]   wb_data;
  logic [RIDX_W-1:0] byp_rs_idx;
  logic              byp_hit;
  logic [XLEN-1:0]   byp_data;

  modport slave (
    input  flush, s0_valid, s0_rd_wen, s0_rd_idx, s0_word, s0_alu_result,
           wb_ready, byp_rs_idx,
    output s0_ready, wb_valid, wb_rd_idx, wb_data, byp_hit, byp_data
  );

  modport master (
    output flush, s0_valid, s0_rd_wen, s0_rd_idx, s0_word, s0_alu_result,
           wb_ready, byp_rs_idx,
    input  s0_ready, wb_valid, wb_rd_idx, wb_data, byp_hit, byp_data
  );
endinterface

// File: rtl/exu_alu_wb.sv
// ----------------------------------------------------------------------------
// exu_alu_wb
//   ALU writeback buffer sitting one stage after the single-cycle ALU.
//   Valid ALU results that write a non-x0 register are sign-extended for
//   W-ops and queued in a small in-order FIFO; the head is offered to the
//   regfile write port with a valid/ready handshake. A combinational bypass
//   lookup lets the operand stage forward results still in the buffer.
//
//   Ports
//     clk            clock, all state on rising edge
//     rst            synchronous active-high reset (priority over flush)
//     bus            exu_alu_wb_if.slave: s0_* input beat, wb_* regfile
//                    write port, byp_* forwarding lookup, flush
//     perf_stall_cnt (only with EXU_ALU_WB_PERF_EN) saturating count of
//                    cycles with s0_valid & ~s0_ready; cleared by rst only
//
//   Configuration macro: EXU_ALU_WB_PERF_EN
// ----------------------------------------------------------------------------
module exu_alu_wb #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  exu_alu_wb_if.slave  bus
`ifdef EXU_ALU_WB_PERF_EN
  ,
  output logic [31:0]  perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;
  logic [RIDX_W-1:0]       idx_mem  [DEPTH];
  logic signed [XLEN-1:0]  data_mem [DEPTH];

  logic                    not_full;
  logic                    push;
  logic                    pop;
  logic signed [XLEN-1:0]  wr_data_p0;
  logic [PTR_W-1:0]        slot;
  logic                    byp_hit_c;
  logic signed [XLEN-1:0]  byp_data_c;

  function automatic logic signed [XLEN-1:0] sext_word(
    input logic signed [XLEN-1:0] r,
    input logic                   word
  );
    if (word) return {{(XLEN-32){r[31]}}, r[31:0]};
    return r;
  endfunction

  // When full, a regfile accept frees the head in the same edge, so the
  // ready path deliberately looks through to wb_ready.
  assign not_full     = count < CNT_W'(DEPTH);
  assign bus.s0_ready = not_full | bus.wb_ready;

  // Beats without a real destination are accepted but never stored.
  assign push = bus.s0_valid & bus.s0_ready & ~bus.flush & bus.s0_rd_wen &
                (bus.s0_rd_idx != '0);
  assign pop  = bus.wb_valid & bus.wb_ready;

  assign wr_data_p0 = sext_word(signed'(bus.s0_alu_result), bus.s0_word);

  // ---- stage p0 -> storage: capture result into the FIFO ----
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr]  <= bus.s0_rd_idx;
      data_mem[wr_ptr] <= wr_data_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---- storage -> regfile write port ----
  // Data storage carries no reset; gating with valid gives clean zeros
  // out of reset and while empty.
  assign bus.wb_valid  = (count != '0);
  assign bus.wb_rd_idx = bus.wb_valid ? idx_mem[rd_ptr] : '0;
  assign bus.wb_data   = bus.wb_valid ? data_mem[rd_ptr] : '0;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    byp_hit_c  = 1'b0;
    byp_data_c = '0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (bus.byp_rs_idx != '0) &&
          (idx_mem[slot] == bus.byp_rs_idx)) begin
        byp_hit_c  = 1'b1;
        byp_data_c = data_mem[slot];
      end
    end
  end

  assign bus.byp_hit  = byp_hit_c;
  assign bus.byp_data = byp_data_c;

`ifdef EXU_ALU_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (bus.s0_valid && !bus.s0_ready && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_alu_wb.sv
module tb_exu_alu_wb;
  localparam int XLEN   = 64;
  localparam int RIDX_W = 5;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_alu_wb_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) bus ();

`ifdef EXU_ALU_WB_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  exu_alu_wb #(.XLEN(XLEN), .RIDX_W(RIDX_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef EXU_ALU_WB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } ent_t;

  // Reference model: the buffer contents as an ordered list of writes.
  ent_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0]     perf_model = 0;
  logic            m_hit;
  logic [XLEN-1:0] m_data;
  logic            m_rdy;

  always @(negedge clk) begin
    if (rst) begin
      perf_model = 0;
    end else begin
      m_rdy = (q.size() < DEPTH) || bus.wb_ready;
      chk("wb_valid", 64'(bus.wb_valid), 64'(q.size() != 0));
      chk("s0_ready", 64'(bus.s0_ready), 64'(m_rdy));
      m_hit  = 1'b0;
      m_data = '0;
      if (bus.byp_rs_idx != 0) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].rd == bus.byp_rs_idx) begin
            m_hit  = 1'b1;
            m_data = q[i].data;
          end
        end
      end
      chk("byp_hit", 64'(bus.byp_hit), 64'(m_hit));
      chk("byp_data", bus.byp_data, m_data);
      if (q.size() != 0 && bus.wb_ready) begin
        chk("wb_rd_idx", 64'(bus.wb_rd_idx), 64'(q[0].rd));
        chk("wb_data", bus.wb_data, q[0].data);
        void'(q.pop_front());
      end
`ifdef EXU_ALU_WB_PERF_EN
      chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(perf_model));
      if (bus.s0_valid && !m_rdy && perf_model != 32'hFFFF_FFFF) perf_model++;
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic last_ready;

  // Called 1 time unit after a rising edge; drives one cycle of inputs and
  // records the beat in the model at the following edge.
  task automatic cyc(input logic v, input logic wen, input logic [RIDX_W-1:0] rd,
                     input logic word, input logic [XLEN-1:0] res, input logic wbr,
                     input logic [RIDX_W-1:0] byp, input logic fl);
    logic            acc;
    logic [XLEN-1:0] expd;
    bus.s0_valid      = v;
    bus.s0_rd_wen     = wen;
    bus.s0_rd_idx     = rd;
    bus.s0_word       = word;
    bus.s0_alu_result = res;
    bus.wb_ready      = wbr;
    bus.byp_rs_idx    = byp;
    bus.flush         = fl;
    #2;
    last_ready = bus.s0_ready;
    acc  = v && ((q.size() < DEPTH) || wbr) && !fl && !rst && wen && (rd != 0);
    expd = word ? 64'($signed(res[31:0])) : res;
    @(posedge clk);
    if (rst || fl) q.delete();
    else if (acc) q.push_back('{rd, expd});
    #1;
  endtask

  task automatic idle(input logic wbr, input logic [RIDX_W-1:0] byp);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, wbr, byp, 1'b0);
  endtask

  logic [31:0] p0;

  initial begin
    bus.s0_valid = 0; bus.s0_rd_wen = 0; bus.s0_rd_idx = 0; bus.s0_word = 0;
    bus.s0_alu_result = 0; bus.wb_ready = 0; bus.byp_rs_idx = 3; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_rd_idx", 64'(bus.wb_rd_idx), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_byp_hit", 64'(bus.byp_hit), 64'd0);
    chk("rst_byp_data", bus.byp_data, 64'd0);
`ifdef EXU_ALU_WB_PERF_EN
    chk("rst_perf", 64'(perf_stall_cnt), 64'd0);
`endif

    // 1. single push, visible next cycle
    cyc(1, 1, 5, 0, 64'h1234, 1, 0, 0);
    chk("t1_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_rd", 64'(bus.wb_rd_idx), 64'd5);
    chk("t1_data", bus.wb_data, 64'h1234);
    idle(1, 0);
    chk("t1_empty", 64'(bus.wb_valid), 64'd0);

    // 2. W-op sign extension
    cyc(1, 1, 9, 1, 64'h0000_0000_8000_0001, 0, 0, 0);
    chk("t2_data", bus.wb_data, 64'hFFFF_FFFF_8000_0001);
    idle(1, 0);

    // 3. fill, stall, then simultaneous pop+push keeps order
    cyc(1, 1, 1, 0, 64'h11, 0, 0, 0);
    cyc(1, 1, 2, 0, 64'h22, 0, 0, 0);
    cyc(1, 1, 3, 0, 64'h33, 0, 0, 0);
    chk("t3_stall_ready", 64'(last_ready), 64'd0);
    chk("t3_head1", 64'(bus.wb_rd_idx), 64'd1);
    cyc(1, 1, 3, 0, 64'h33, 1, 0, 0);
    chk("t3_popush_ready", 64'(last_ready), 64'd1);
    chk("t3_head2", 64'(bus.wb_rd_idx), 64'd2);
    idle(1, 0);
    chk("t3_head3", 64'(bus.wb_rd_idx), 64'd3);
    idle(1, 0);
    chk("t3_empty", 64'(bus.wb_valid), 64'd0);

    // 4. bypass youngest wins; x0 never hits
    cyc(1, 1, 7, 0, 64'hA, 0, 7, 0);
    cyc(1, 1, 7, 0, 64'hB, 0, 7, 0);
    idle(0, 7);
    chk("t4_hit", 64'(bus.byp_hit), 64'd1);
    chk("t4_data", bus.byp_data, 64'hB);
    idle(0, 0);
    chk("t4_x0_hit", 64'(bus.byp_hit), 64'd0);
    idle(1, 0);
    idle(1, 0);

    // 5. x0 and no-wen beats accepted but dropped
    cyc(1, 1, 0, 0, 64'h55, 1, 0, 0);
    chk("t5_ready0", 64'(last_ready), 64'd1);
    cyc(1, 0, 3, 0, 64'h66, 0, 3, 0);
    chk("t5_ready1", 64'(last_ready), 64'd1);
    chk("t5_novalid", 64'(bus.wb_valid), 64'd0);
    idle(0, 3);
    chk("t5_novalid2", 64'(bus.wb_valid), 64'd0);

    // 6. fill, stall 4 cycles, flush with concurrent push
    cyc(1, 1, 1, 0, 64'h101, 0, 1, 0);
    cyc(1, 1, 2, 0, 64'h102, 0, 1, 0);
`ifdef EXU_ALU_WB_PERF_EN
    p0 = perf_stall_cnt;
`else
    p0 = 0;
`endif
    repeat (4) cyc(1, 1, 4, 0, 64'h104, 0, 1, 0);
`ifdef EXU_ALU_WB_PERF_EN
    chk("t6_perf_delta", 64'(perf_stall_cnt - p0), 64'd4);
`endif
    cyc(1, 1, 4, 0, 64'h104, 0, 1, 1);
    chk("t6_flush_valid", 64'(bus.wb_valid), 64'd0);
    chk("t6_flush_hit", 64'(bus.byp_hit), 64'd0);
    idle(0, 1);

    // mid-operation reset drops entries
    cyc(1, 1, 6, 0, 64'h6, 0, 6, 0);
    rst = 1'b1;
    idle(0, 6);
    rst = 1'b0;
    chk("midrst_valid", 64'(bus.wb_valid), 64'd0);
    chk("midrst_hit", 64'(bus.byp_hit), 64'd0);
`ifdef EXU_ALU_WB_PERF_EN
    chk("midrst_perf", 64'(perf_stall_cnt), 64'd0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc(($urandom % 4) != 0, ($urandom % 8) != 0, RIDX_W'($urandom_range(0, 7)),
          1'($urandom % 2), {$urandom, $urandom}, 1'($urandom % 2),
          RIDX_W'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
    end
    rst = 1'b0;
    repeat (4) idle(1, 0);
    chk("final_empty", 64'(bus.wb_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
